bus_key_sequencer: RTL and testbench
====================================

// Module: bus_key_sequencer
// PURPOSE
//  Parametrised bus-side key sequencer. Watches qualified read accesses to its decoded window and matches
//  their address symbols against a KEY_LEN-symbol key. On a full match it unlocks and returns LFSR-generated
//  response bits on subsequent reads. Wrong symbols count toward a timed lockout.
//  Adds configurable key, response width, response length, explicit relock and lockout.
// PARAMETERS
//  SYM_W        4          width of one key symbol (address bits sampled per access)
//  KEY_LEN      4          symbols in key, >=1
//  KEY          16'h5A39   packed key; symbol i = KEY[i*SYM_W +: SYM_W], symbol 0 first
//  DATA_W       2          response bits per read, <= LFSR_W
//  LFSR_W       8          response LFSR width
//  LFSR_TAPS    8'hB8      Galois tap mask
//  LFSR_SEED    8'h01      LFSR value loaded on reset and on every unlock; nonzero
//  RESP_LEN     16         reads served while unlocked before auto-relock, >=1
//  RELOCK_SYM   4'hF       symbol that forces relock while unlocked
//  MAX_FAIL     3          consecutive mismatches that trigger lockout, >=1
//  LOCKOUT_CYC  1024       clk cycles spent in lockout, >=1
// PORTS
//  clk        in   1                 single clock, all state on rising edge
//  rst        in   1                 synchronous, active-high reset
//  acc_valid  in   1                 one-cycle strobe per bus access
//  acc_sel    in   1                 window decode (chip select, high = ours)
//  acc_rw     in   1                 1 = read, 0 = write
//  acc_sym    in   SYM_W             address symbol of the access
//  rd_data    out  DATA_W            response bits, registered
//  rd_valid   out  1                 one-cycle pulse, rd_data valid
//  unlocked   out  1                 state == UNLOCKED
//  lockout    out  1                 state == LOCKOUT
//  key_idx    out  $clog2(KEY_LEN+1) symbols matched so far
// BEHAVIOUR
//  - Qualified access q = acc_valid & acc_sel & acc_rw. Writes and deselected cycles change nothing.
//  - Reset: state LOCKED, key_idx 0, fail_cnt 0, lfsr LFSR_SEED, served 0.
//    rd_data 0, rd_valid 0, unlocked 0, lockout 0. rst wins over any same-cycle access.
//  - LOCKED, on q:
//      acc_sym == KEY[key_idx]: key_idx+1 and fail_cnt 0. If this completes the key (key_idx == KEY_LEN-1),
//      go to UNLOCKED, key_idx 0, lfsr LFSR_SEED, served 0.
//      Mismatch: key_idx <= (acc_sym == KEY[0]) ? 1 : 0, and fail_cnt+1. If fail_cnt+1 == MAX_FAIL, go to LOCKOUT
//      with timer LOCKOUT_CYC-1 and key_idx 0. A mismatch that restarts at 1 still counts as a fail.
//      Completing the key and restart-at-1 are mutually exclusive. With KEY_LEN=1, a single matching access unlocks.
//      Response: rd_data = all ones.
//  - UNLOCKED, on q:
//      rd_data <= lfsr[DATA_W-1:0] (pre-step value), then lfsr steps: lfsr = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
//      served+1. If acc_sym == RELOCK_SYM, or served+1 == RESP_LEN, go to LOCKED with fail_cnt 0.
//      That access still returns LFSR data.
//  - LOCKOUT: timer decrements every clk, whether or not there is an access. Accesses return all ones
//    and do not affect matching. At timer 0 go to LOCKED with fail_cnt 0.
//  - rd_valid pulses on the cycle after every q, in every state. Latency is 1 clk.
//    Back-to-back q strobes give back-to-back pulses.
//  - Outputs unlocked, lockout, key_idx are registered and follow the state directly.
// STRUCTURE
//  - Package key_seq_pkg: state enum {LOCKED, UNLOCKED, LOCKOUT}; function lfsr_step(val, taps);
//    function key_sym(key, i).
//  - Sub-module key_lfsr (LFSR_W, TAPS, SEED): ports load, step, value. This module holds only the FSM
//    and counters. Counter widths come from $clog2 of their maxima.
// TESTING (defaults)
//  1 Reset, then reads with symbols 9,3,A,5: key_idx goes 1,2,3,0; unlocked=1 one cycle after the 4th access.
//    rd_data is 2'b11 on all four.
//  2 Unlocked, 4 reads of symbol 0: rd_data 01,00,00,10 (lfsr 01,B8,5C,2E).
//    rd_valid one cycle after each read.
//  3 Unlocked, 16th read: returns data, then unlocked=0. Read of symbol F at read 3: data returned, unlocked=0.
//  4 Reads 9,3,9: key_idx 1,2,1 (restart) and fail_cnt 1. Then 7,7: lockout=1.
//    Key sequence ignored for 1024 clks; exits to LOCKED, after which the key unlocks normally.
//  5 Writes and acc_sel=0 reads carrying the key: no state change, no rd_valid.
//    rst asserted while unlocked, during a read: all outputs take reset values the next cycle.
//  6 Param KEY_LEN=1, KEY=4'h6, DATA_W=1: a single read of 6 unlocks.
//    The next read returns lfsr[0]=1.

Source files
------------

// File: rtl/key_seq_pkg.sv
// Shared types and helpers for the bus key sequencer.
package key_seq_pkg;

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      UNLOCKED = 2'd1,
      LOCKOUT  = 2'd2
   } state_t;

   // One Galois LFSR step; callers zero-extend into 32 bits and truncate the result.
   function automatic logic [31:0] lfsr_step(input logic [31:0] val, input logic [31:0] taps);
      lfsr_step = (val >> 1) ^ (val[0] ? taps : 32'd0);
   endfunction

   // Symbol i of a packed key, symbol 0 in the least significant bits.
   function automatic logic [31:0] key_sym(input logic [63:0] key, input int i, input int sym_w);
      key_sym = 32'((key >> (i * sym_w)) & ((64'd1 << sym_w) - 64'd1));
   endfunction

endpackage

// File: rtl/key_lfsr.sv
// Response LFSR: reloads the seed on reset or load, otherwise advances one step per step strobe.
module key_lfsr
   import key_seq_pkg::*;
#(
   parameter int                LFSR_W = 8,
   parameter logic [LFSR_W-1:0] TAPS   = 8'hB8,
   parameter logic [LFSR_W-1:0] SEED   = 8'h01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic [LFSR_W-1:0] value
);

   // Seed load has priority over stepping.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         value <= SEED;
      end else if (step) begin
         value <= LFSR_W'(lfsr_step(32'(value), 32'(TAPS)));
      end
   end

endmodule

// File: rtl/bus_key_sequencer.sv
// Bus key sequencer: matches read address symbols against a key, then serves LFSR
// response bits until relock; repeated mismatches force a timed lockout.
module bus_key_sequencer
   import key_seq_pkg::*;
#(
   parameter int                        SYM_W       = 4,
   parameter int                        KEY_LEN     = 4,
   parameter logic [KEY_LEN*SYM_W-1:0]  KEY         = 16'h5A39,
   parameter int                        DATA_W      = 2,
   parameter int                        LFSR_W      = 8,
   parameter logic [LFSR_W-1:0]         LFSR_TAPS   = 8'hB8,
   parameter logic [LFSR_W-1:0]         LFSR_SEED   = 8'h01,
   parameter int                        RESP_LEN    = 16,
   parameter logic [SYM_W-1:0]          RELOCK_SYM  = 4'hF,
   parameter int                        MAX_FAIL    = 3,
   parameter int                        LOCKOUT_CYC = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         acc_valid,
   input  logic                         acc_sel,
   input  logic                         acc_rw,
   input  logic [SYM_W-1:0]             acc_sym,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_valid,
   output logic                         unlocked,
   output logic                         lockout,
   output logic [$clog2(KEY_LEN+1)-1:0] key_idx
);

   localparam int KIW = $clog2(KEY_LEN + 1);
   localparam int FW  = $clog2(MAX_FAIL + 1);
   localparam int TW  = $clog2(LOCKOUT_CYC + 1);
   localparam int SW  = $clog2(RESP_LEN + 1);

   state_t            state;
   logic [FW-1:0]     fail_cnt;
   logic [TW-1:0]     timer;
   logic [SW-1:0]     served;
   logic              q;
   logic [SYM_W-1:0]  cur_sym;
   logic [SYM_W-1:0]  first_sym;
   logic              sym_match;
   logic              key_done;
   logic              do_load;
   logic              do_step;
   logic [LFSR_W-1:0] lfsr_val;
   logic              unused_lfsr;

   assign q         = acc_valid & acc_sel & acc_rw;
   assign cur_sym   = SYM_W'(key_sym(64'(KEY), int'(key_idx), SYM_W));
   assign first_sym = SYM_W'(key_sym(64'(KEY), 0, SYM_W));
   assign sym_match = (acc_sym == cur_sym);
   assign key_done  = (key_idx == KIW'(KEY_LEN - 1));
   assign do_load   = q && (state == LOCKED) && sym_match && key_done;
   assign do_step   = q && (state == UNLOCKED);
   assign unlocked  = (state == UNLOCKED);
   assign lockout   = (state == LOCKOUT);
   // Only the low DATA_W LFSR bits reach the bus; the rest is folded here to mark it intentionally unused.
   assign unused_lfsr = ^lfsr_val;

   key_lfsr #(
      .LFSR_W (LFSR_W),
      .TAPS   (LFSR_TAPS),
      .SEED   (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (do_load),
      .step  (do_step),
      .value (lfsr_val)
   );

   // Sequencer FSM, counters and registered read response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOCKED;
         key_idx  <= '0;
         fail_cnt <= '0;
         timer    <= '0;
         served   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= q;
         case (state)
            LOCKED: begin
               if (q) begin
                  rd_data <= '1;
                  if (sym_match) begin
                     fail_cnt <= '0;
                     if (key_done) begin
                        state   <= UNLOCKED;
                        key_idx <= '0;
                        served  <= '0;
                     end else begin
                        key_idx <= key_idx + KIW'(1);
                     end
                  end else begin
                     // A wrong symbol that equals the first key symbol restarts the match at 1.
                     key_idx  <= (acc_sym == first_sym) ? KIW'(1) : '0;
                     fail_cnt <= fail_cnt + FW'(1);
                     if ((fail_cnt + FW'(1)) == FW'(MAX_FAIL)) begin
                        state   <= LOCKOUT;
                        timer   <= TW'(LOCKOUT_CYC - 1);
                        key_idx <= '0;
                     end
                  end
               end
            end
            UNLOCKED: begin
               if (q) begin
                  rd_data <= lfsr_val[DATA_W-1:0];
                  served  <= served + SW'(1);
                  if ((acc_sym == RELOCK_SYM) || ((served + SW'(1)) == SW'(RESP_LEN))) begin
                     state    <= LOCKED;
                     fail_cnt <= '0;
                  end
               end
            end
            LOCKOUT: begin
               if (q) begin
                  rd_data <= '1;
               end
               if (timer == '0) begin
                  state    <= LOCKED;
                  fail_cnt <= '0;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= LOCKED;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Self-checking bench for bus_key_sequencer: directed scenarios plus random traffic
// compared against a behavioural model of the access rules.
module tb_bus_key_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       acc_valid = 1'b0;
   logic       acc_sel = 1'b0;
   logic       acc_rw = 1'b0;
   logic [3:0] acc_sym = 4'h0;
   logic [1:0] rd_data;
   logic       rd_valid;
   logic       unlocked;
   logic       lockout;
   logic [2:0] key_idx;

   logic       b_rst = 1'b1;
   logic       b_valid = 1'b0;
   logic       b_sel = 1'b0;
   logic       b_rw = 1'b0;
   logic [3:0] b_sym = 4'h0;
   logic [0:0] b_data;
   logic       b_rd_valid;
   logic       b_unlocked;
   logic       b_lockout;
   logic [0:0] b_key_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_key_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .acc_valid (acc_valid),
      .acc_sel   (acc_sel),
      .acc_rw    (acc_rw),
      .acc_sym   (acc_sym),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .unlocked  (unlocked),
      .lockout   (lockout),
      .key_idx   (key_idx)
   );

   bus_key_sequencer #(
      .KEY_LEN (1),
      .KEY     (4'h6),
      .DATA_W  (1)
   ) dut1 (
      .clk       (clk),
      .rst       (b_rst),
      .acc_valid (b_valid),
      .acc_sel   (b_sel),
      .acc_rw    (b_rw),
      .acc_sym   (b_sym),
      .rd_data   (b_data),
      .rd_valid  (b_rd_valid),
      .unlocked  (b_unlocked),
      .lockout   (b_lockout),
      .key_idx   (b_key_idx)
   );

   // Behavioural model: mode 0 = locked, 1 = unlocked, 2 = lockout.
   int key_tab [4] = '{9, 3, 10, 5};
   int m_mode, m_idx, m_fail, m_lfsr, m_served, m_timer, m_data, m_valid;

   task automatic model_clk(input bit qual, input int sym);
      if (rst) begin
         m_mode = 0; m_idx = 0; m_fail = 0; m_lfsr = 1; m_served = 0;
         m_timer = 0; m_data = 0; m_valid = 0;
         return;
      end
      m_valid = qual;
      if (m_mode == 0) begin
         if (qual) begin
            m_data = 3;
            if (sym == key_tab[m_idx]) begin
               m_fail = 0;
               if (m_idx == 3) begin
                  m_mode = 1; m_idx = 0; m_lfsr = 1; m_served = 0;
               end else begin
                  m_idx++;
               end
            end else begin
               m_idx = (sym == key_tab[0]) ? 1 : 0;
               m_fail++;
               if (m_fail == 3) begin
                  m_mode = 2; m_timer = 1023; m_idx = 0;
               end
            end
         end
      end else if (m_mode == 1) begin
         if (qual) begin
            m_data = m_lfsr % 4;
            m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 'hB8 : 0);
            m_served++;
            if (sym == 15 || m_served == 16) begin
               m_mode = 0; m_fail = 0;
            end
         end
      end else begin
         if (qual) m_data = 3;
         if (m_timer == 0) begin
            m_mode = 0; m_fail = 0;
         end else begin
            m_timer--;
         end
      end
   endtask

   task automatic cyc(input logic v, input logic s, input logic rw, input logic [3:0] sym);
      acc_valid = v; acc_sel = s; acc_rw = rw; acc_sym = sym;
      @(posedge clk);
      model_clk(v & s & rw, int'(sym));
      #1;
      acc_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] sym);
      cyc(1'b1, 1'b1, 1'b1, sym);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rd(4'h9);
      rd(4'h3);
      checks++; if (rd_data !== 2'b00)  begin errors++; $display("FAIL reset_rd_data got %0h want 0", rd_data); end
      checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
      checks++; if (unlocked !== 1'b0)  begin errors++; $display("FAIL reset_unlocked got %0b want 0", unlocked); end
      checks++; if (lockout !== 1'b0)   begin errors++; $display("FAIL reset_lockout got %0b want 0", lockout); end
      checks++; if (key_idx !== 3'd0)   begin errors++; $display("FAIL reset_key_idx got %0d want 0", key_idx); end
      rst = 1'b0;
   endtask

   task automatic test_unlock;
      logic [3:0] syms [4] = '{4'h9, 4'h3, 4'hA, 4'h5};
      logic [2:0] exp_idx [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
      for (int i = 0; i < 4; i++) begin
         rd(syms[i]);
         checks++; if (key_idx !== exp_idx[i]) begin errors++; $display("FAIL unlock_key_idx[%0d] got %0d want %0d", i, key_idx, exp_idx[i]); end
         checks++; if (rd_valid !== 1'b1 || rd_data !== 2'b11) begin errors++; $display("FAIL unlock_rd[%0d] got v=%0b d=%0h want v=1 d=3", i, rd_valid, rd_data); end
         checks++; if (unlocked !== (i == 3)) begin errors++; $display("FAIL unlock_flag[%0d] got %0b want %0b", i, unlocked, i == 3); end
      end
   endtask

   task automatic test_response;
      logic [1:0] exp_d [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
      for (int i = 0; i < 4; i++) begin
         rd(4'h0);
         checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin errors++; $display("FAIL resp_data[%0d] got v=%0b d=%0h want v=1 d=%0h", i, rd_valid, rd_data, exp_d[i]); end
         cyc(1'b0, 1'b0, 1'b0, 4'h0);
         checks++; if (rd_valid !== 1'b0 || unlocked !== 1'b1) begin errors++; $display("FAIL resp_idle[%0d] got v=%0b u=%0b want v=0 u=1", i, rd_valid, unlocked); end
      end
   endtask

   task automatic test_relock;
      logic [3:0] syms [4] = '{4'h9, 4'h3, 4'hA, 4'h5};
      for (int i = 5; i <= 16; i++) begin
         rd(4'h0);
         checks++; if (rd_valid !== 1'b1 || rd_data !== 2'(m_data)) begin errors++; $display("FAIL relock_len_data[%0d] got %0h want %0h", i, rd_data, m_data); end
         checks++; if (unlocked !== (i < 16)) begin errors++; $display("FAIL relock_len_flag[%0d] got %0b want %0b", i, unlocked, i < 16); end
      end
      for (int i = 0; i < 4; i++) rd(syms[i]);
      checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL relock_reunlock got %0b want 1", unlocked); end
      rd(4'h0);
      rd(4'h0);
      rd(4'hF);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 2'b00) begin errors++; $display("FAIL relock_sym_data got v=%0b d=%0h want v=1 d=0", rd_valid, rd_data); end
      checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL relock_sym_flag got %0b want 0", unlocked); end
   endtask

   task automatic test_lockout;
      logic [3:0] syms [4] = '{4'h9, 4'h3, 4'hA, 4'h5};
      int n;
      int bad;
      rd(4'h9); rd(4'h3); rd(4'h9);
      checks++; if (key_idx !== 3'd1) begin errors++; $display("FAIL lock_restart got %0d want 1", key_idx); end
      rd(4'h7);
      checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL lock_early got %0b want 0", lockout); end
      rd(4'h7);
      checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL lock_enter got %0b want 1", lockout); end
      n = 1;
      bad = 0;
      while (lockout === 1'b1 && n < 2000) begin
         rd(syms[n % 4]);
         if (key_idx !== 3'd0 || unlocked !== 1'b0 || rd_data !== 2'b11) bad++;
         if (lockout === 1'b1) n++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL lock_ignore got %0d bad cycles want 0", bad); end
      checks++; if (n != 1024 || m_mode != 0) begin errors++; $display("FAIL lock_duration got %0d want 1024", n); end
      for (int i = 0; i < 4; i++) rd(syms[i]);
      checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL lock_after_unlock got %0b want 1", unlocked); end
   endtask

   task automatic test_ignore;
      logic [3:0] syms [4] = '{4'h9, 4'h3, 4'hA, 4'h5};
      rd(4'hF);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, 1'b0, syms[i]);
         checks++; if (rd_valid !== 1'b0 || key_idx !== 3'd0) begin errors++; $display("FAIL ignore_write[%0d] got v=%0b k=%0d want v=0 k=0", i, rd_valid, key_idx); end
         cyc(1'b1, 1'b0, 1'b1, syms[i]);
         checks++; if (rd_valid !== 1'b0 || key_idx !== 3'd0 || unlocked !== 1'b0) begin errors++; $display("FAIL ignore_desel[%0d] got v=%0b k=%0d u=%0b want 0", i, rd_valid, key_idx, unlocked); end
      end
   endtask

   task automatic test_reset_unlocked;
      logic [3:0] syms [4] = '{4'h9, 4'h3, 4'hA, 4'h5};
      for (int i = 0; i < 4; i++) rd(syms[i]);
      rd(4'h0);
      rst = 1'b1;
      rd(4'h0);
      checks++; if (rd_valid !== 1'b0 || rd_data !== 2'b00 || unlocked !== 1'b0 || lockout !== 1'b0 || key_idx !== 3'd0) begin
         errors++; $display("FAIL rst_unlocked got v=%0b d=%0h u=%0b l=%0b k=%0d want all 0", rd_valid, rd_data, unlocked, lockout, key_idx);
      end
      rst = 1'b0;
   endtask

   task automatic test_random;
      logic       v, s, rw;
      logic [3:0] sym;
      int         r;
      for (int c = 0; c < 4000; c++) begin
         v  = ($urandom_range(0, 3) != 0);
         s  = ($urandom_range(0, 7) != 0);
         rw = ($urandom_range(0, 5) != 0);
         r  = $urandom_range(0, 9);
         if (r < 6)       sym = 4'(key_tab[m_idx]);
         else if (r == 6) sym = 4'hF;
         else             sym = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 999) == 0);
         cyc(v, s, rw, sym);
         rst = 1'b0;
         checks++; if (rd_valid !== 1'(m_valid)) begin errors++; $display("FAIL rand_rd_valid c=%0d got %0b want %0b", c, rd_valid, m_valid); end
         if (m_valid == 1) begin
            checks++; if (rd_data !== 2'(m_data)) begin errors++; $display("FAIL rand_rd_data c=%0d got %0h want %0h", c, rd_data, m_data); end
         end
         checks++; if (unlocked !== (m_mode == 1) || lockout !== (m_mode == 2)) begin errors++; $display("FAIL rand_state c=%0d got u=%0b l=%0b want mode %0d", c, unlocked, lockout, m_mode); end
         checks++; if (key_idx !== 3'(m_idx)) begin errors++; $display("FAIL rand_key_idx c=%0d got %0d want %0d", c, key_idx, m_idx); end
      end
   endtask

   task automatic b_rd(input logic [3:0] sym);
      b_valid = 1'b1; b_sel = 1'b1; b_rw = 1'b1; b_sym = sym;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
   endtask

   task automatic test_keylen1;
      b_rst = 1'b1;
      @(posedge clk);
      #1;
      b_rst = 1'b0;
      b_rd(4'h2);
      checks++; if (b_unlocked !== 1'b0 || b_data !== 1'b1) begin errors++; $display("FAIL k1_miss got u=%0b d=%0b want u=0 d=1", b_unlocked, b_data); end
      b_rd(4'h6);
      checks++; if (b_unlocked !== 1'b1 || b_key_idx !== 1'b0) begin errors++; $display("FAIL k1_unlock got u=%0b k=%0b want u=1 k=0", b_unlocked, b_key_idx); end
      b_rd(4'h0);
      checks++; if (b_rd_valid !== 1'b1 || b_data !== 1'b1) begin errors++; $display("FAIL k1_data0 got v=%0b d=%0b want v=1 d=1", b_rd_valid, b_data); end
      b_rd(4'h0);
      checks++; if (b_data !== 1'b0 || b_lockout !== 1'b0) begin errors++; $display("FAIL k1_data1 got d=%0b l=%0b want d=0 l=0", b_data, b_lockout); end
   endtask

   initial begin
      m_mode = 0; m_idx = 0; m_fail = 0; m_lfsr = 1; m_served = 0;
      m_timer = 0; m_data = 0; m_valid = 0;
      test_reset();
      test_unlock();
      test_response();
      test_relock();
      test_lockout();
      test_ignore();
      test_reset_unlocked();
      test_random();
      test_keylen1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
